// File: rtl/vx_reg_window_mgr.sv
// Per-warp register-window manager: CWP tracking, arch->phys remap,
// spill/fill sequencing against an external memory engine.
module vx_reg_window_mgr #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned R           = 5,
  parameter int unsigned NUM_GLOBALS = 8,
  parameter int unsigned NUM_WINDOWS = 4,
  parameter int unsigned STRIDE      = 16,
  parameter int unsigned DEPTH_BITS  = 4,
  localparam int unsigned WB         = $clog2(NUM_WARPS),
  localparam int unsigned PER_WARP   = NUM_GLOBALS + NUM_WINDOWS * STRIDE,
  localparam int unsigned P          = $clog2(NUM_WARPS * PER_WARP),
  localparam int unsigned MCW        = $clog2(STRIDE) + 1
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 op_valid,
  input  logic                 op_save,
  input  logic [WB-1:0]        op_warp,
  output logic                 op_ready,
  input  logic [WB-1:0]        dec_warp,
  input  logic [R-1:0]         rs1,
  input  logic [R-1:0]         rs2,
  input  logic [R-1:0]         rd,
  output logic [P-1:0]         rs1_o,
  output logic [P-1:0]         rs2_o,
  output logic [P-1:0]         rd_o,
  output logic [NUM_WARPS-1:0] deschedule,
  output logic                 spill_valid,
  output logic                 fill_valid,
  input  logic                 mem_ready,
  output logic [WB-1:0]        mem_warp,
  output logic [P-1:0]         mem_base,
  output logic [MCW-1:0]       mem_count,
  input  logic                 mem_done,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  localparam int unsigned CW       = $clog2(NUM_WINDOWS);
  localparam int unsigned RSW      = $clog2(NUM_WINDOWS) + 1;
  localparam int unsigned SPL_MAX  = (2 ** DEPTH_BITS) - 1;
  localparam int unsigned WIN_SPAN = NUM_WINDOWS * STRIDE;

  typedef enum logic [1:0] {IDLE, SPILL_REQ, FILL_REQ, WAIT_DONE} state_t;

  state_t                state_q, state_n;
  logic [CW-1:0]         cwp_q [NUM_WARPS];
  logic [CW-1:0]         cwp_n [NUM_WARPS];
  logic [RSW-1:0]        res_q [NUM_WARPS];
  logic [RSW-1:0]        res_n [NUM_WARPS];
  logic [DEPTH_BITS-1:0] spl_q [NUM_WARPS];
  logic [DEPTH_BITS-1:0] spl_n [NUM_WARPS];
  logic                  xsave_q, xsave_n;
  logic [WB-1:0]         w;
  logic [WB-1:0]         mem_warp_n;
  logic [P-1:0]          mem_base_n;
  logic                  ovf_n, unf_n, busy_n;
  logic [NUM_WARPS-1:0]  desched_n;

  // First physical register of window o in warp wi.
  function automatic logic [P-1:0] win_base(input logic [WB-1:0] wi, input logic [CW-1:0] o);
    return P'(wi) * P'(PER_WARP) + P'(NUM_GLOBALS) + P'(o) * P'(STRIDE);
  endfunction

  // Architectural -> physical index; windowed regs rotate with cwp.
  function automatic logic [P-1:0] map_reg(input logic [WB-1:0] wi, input logic [R-1:0] a,
                                           input logic [CW-1:0] c);
    int unsigned base, win;
    base = 32'(wi) * PER_WARP;
    if (32'(a) < NUM_GLOBALS) return P'(base + 32'(a));
    win = (32'(c) * STRIDE + (32'(a) - NUM_GLOBALS)) % WIN_SPAN;
    return P'(base + NUM_GLOBALS + win);
  endfunction

  // Combinational decode against the registered window pointer.
  always_comb begin
    rs1_o = map_reg(dec_warp, rs1, cwp_q[dec_warp]);
    rs2_o = map_reg(dec_warp, rs2, cwp_q[dec_warp]);
    rd_o  = map_reg(dec_warp, rd,  cwp_q[dec_warp]);
  end

  // Next-state: op acceptance, trap entry, transfer handshake and commit.
  always_comb begin
    state_n    = state_q;
    xsave_n    = xsave_q;
    mem_warp_n = mem_warp;
    mem_base_n = mem_base;
    ovf_n      = 1'b0;
    unf_n      = 1'b0;
    w          = op_warp;
    for (int i = 0; i < NUM_WARPS; i++) begin
      cwp_n[i] = cwp_q[i];
      res_n[i] = res_q[i];
      spl_n[i] = spl_q[i];
    end
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (op_save) begin
            if (res_q[w] < RSW'(NUM_WINDOWS - 1)) begin
              cwp_n[w] = cwp_q[w] + CW'(1);
              res_n[w] = res_q[w] + RSW'(1);
            end else if (spl_q[w] < DEPTH_BITS'(SPL_MAX)) begin
              state_n    = SPILL_REQ;
              xsave_n    = 1'b1;
              mem_warp_n = w;
              mem_base_n = win_base(w, cwp_q[w] - CW'(res_q[w]) + CW'(1));
            end else begin
              ovf_n = 1'b1;
            end
          end else begin
            if (res_q[w] > RSW'(1)) begin
              cwp_n[w] = cwp_q[w] - CW'(1);
              res_n[w] = res_q[w] - RSW'(1);
            end else if (spl_q[w] != '0) begin
              state_n    = FILL_REQ;
              xsave_n    = 1'b0;
              mem_warp_n = w;
              mem_base_n = win_base(w, cwp_q[w] - CW'(1));
            end else begin
              unf_n = 1'b1;
            end
          end
        end
      end
      SPILL_REQ, FILL_REQ: begin
        if (mem_ready) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mem_done) begin
          state_n = IDLE;
          if (xsave_q) begin
            cwp_n[mem_warp] = cwp_q[mem_warp] + CW'(1);
            spl_n[mem_warp] = spl_q[mem_warp] + DEPTH_BITS'(1);
          end else begin
            cwp_n[mem_warp] = cwp_q[mem_warp] - CW'(1);
            spl_n[mem_warp] = spl_q[mem_warp] - DEPTH_BITS'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n    = (state_n != IDLE);
    desched_n = '0;
    if (busy_n) desched_n[mem_warp_n] = 1'b1;
  end

  // State and registered outputs; transfer fields are zero while idle.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q       <= IDLE;
      xsave_q       <= 1'b0;
      op_ready      <= 1'b1;
      deschedule    <= '0;
      spill_valid   <= 1'b0;
      fill_valid    <= 1'b0;
      mem_warp      <= '0;
      mem_base      <= '0;
      mem_count     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        cwp_q[i] <= '0;
        res_q[i] <= RSW'(1);
        spl_q[i] <= '0;
      end
    end else begin
      state_q       <= state_n;
      xsave_q       <= xsave_n;
      op_ready      <= (state_n == IDLE);
      deschedule    <= desched_n;
      spill_valid   <= (state_n == SPILL_REQ);
      fill_valid    <= (state_n == FILL_REQ);
      mem_warp      <= busy_n ? mem_warp_n : '0;
      mem_base      <= busy_n ? mem_base_n : '0;
      mem_count     <= busy_n ? MCW'(STRIDE) : '0;
      err_overflow  <= ovf_n;
      err_underflow <= unf_n;
      for (int i = 0; i < NUM_WARPS; i++) begin
        cwp_q[i] <= cwp_n[i];
        res_q[i] <= res_n[i];
        spl_q[i] <= spl_n[i];
      end
    end
  end

endmodule

// File: tb/tb_vx_reg_window_mgr.sv
// Randomized self-checking bench for vx_reg_window_mgr against a per-warp
// window/depth model.
module tb_vx_reg_window_mgr;

  logic       clk = 1'b0;
  logic       nRST;
  logic       op_valid, op_save;
  logic [1:0] op_warp, dec_warp;
  logic [4:0] rs1, rs2, rd;
  logic [8:0] rs1_o, rs2_o, rd_o;
  logic [3:0] deschedule;
  logic       spill_valid, fill_valid, mem_ready, mem_done;
  logic [1:0] mem_warp;
  logic [8:0] mem_base;
  logic [4:0] mem_count;
  logic       op_ready, err_overflow, err_underflow;

  vx_reg_window_mgr dut (
    .clk(clk), .nRST(nRST), .op_valid(op_valid), .op_save(op_save), .op_warp(op_warp),
    .op_ready(op_ready), .dec_warp(dec_warp), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .deschedule(deschedule),
    .spill_valid(spill_valid), .fill_valid(fill_valid), .mem_ready(mem_ready),
    .mem_warp(mem_warp), .mem_base(mem_base), .mem_count(mem_count), .mem_done(mem_done),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned m_cwp [4];
  int unsigned m_res [4];
  int unsigned m_spl [4];

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cwp[i] = 0;
      m_res[i] = 1;
      m_spl[i] = 0;
    end
  endtask

  // Each warp owns 72 regs: 8 globals, then a 64-entry ring of 16-reg windows.
  function automatic int unsigned ref_phys(input int unsigned w, input int unsigned a);
    if (a < 8) return w * 72 + a;
    return w * 72 + 8 + ((m_cwp[w] * 16 + (a - 8)) % 64);
  endfunction

  task automatic check_decode(input string tag, input int unsigned w);
    dec_warp = 2'(w);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    rd  = 5'($urandom);
    #1;
    chk({tag, "_rs1"}, 32'(rs1_o), ref_phys(w, 32'(rs1)));
    chk({tag, "_rs2"}, 32'(rs2_o), ref_phys(w, 32'(rs2)));
    chk({tag, "_rd"},  32'(rd_o),  ref_phys(w, 32'(rd)));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_spill"}, 32'(spill_valid), 0);
    chk({tag, "_fill"},  32'(fill_valid), 0);
    chk({tag, "_desch"}, 32'(deschedule), 0);
    chk({tag, "_ready"}, 32'(op_ready), 1);
    chk({tag, "_base"},  32'(mem_base), 0);
  endtask

  // Issue one save/restore on warp w and follow it to completion; with
  // abort set, reset is asserted while the transfer waits for mem_done.
  task automatic do_op(input int unsigned w, input bit s, input bit abort);
    int unsigned exp_base, k;
    op_valid = 1'b1;
    op_warp  = 2'(w);
    op_save  = s;
    check_decode("pre", w);
    chk("op_ready", 32'(op_ready), 1);
    step();
    op_valid = 1'b0;
    if (s && m_res[w] < 3) begin
      m_cwp[w] = (m_cwp[w] + 1) % 4;
      m_res[w]++;
      check_idle_outputs("save");
    end else if (!s && m_res[w] > 1) begin
      m_cwp[w] = (m_cwp[w] + 3) % 4;
      m_res[w]--;
      check_idle_outputs("rest");
    end else if ((s && m_spl[w] < 15) || (!s && m_spl[w] > 0)) begin
      if (s) exp_base = w * 72 + 8 + ((m_cwp[w] + 4 - m_res[w] + 1) % 4) * 16;
      else   exp_base = w * 72 + 8 + ((m_cwp[w] + 3) % 4) * 16;
      k = $urandom_range(0, 3);
      for (int i = 0; i <= k; i++) begin
        chk("req_spill", 32'(spill_valid), 32'(s));
        chk("req_fill",  32'(fill_valid), 32'(!s));
        chk("req_warp",  32'(mem_warp), w);
        chk("req_base",  32'(mem_base), exp_base);
        chk("req_count", 32'(mem_count), 16);
        chk("req_desch", 32'(deschedule), 32'(1) << w);
        chk("req_ready", 32'(op_ready), 0);
        check_decode("xfer", $urandom_range(0, 3));
        if (i == k) begin
          mem_ready = 1'b1;
          mem_done  = 1'b1;
        end else begin
          mem_done  = 1'($urandom_range(0, 1));
        end
        op_valid = 1'($urandom_range(0, 1));
        op_warp  = 2'($urandom_range(0, 3));
        step();
        op_valid  = 1'b0;
        mem_ready = 1'b0;
        mem_done  = 1'b0;
      end
      chk("wait_spill", 32'(spill_valid), 0);
      chk("wait_fill",  32'(fill_valid), 0);
      chk("wait_desch", 32'(deschedule), 32'(1) << w);
      chk("wait_ready", 32'(op_ready), 0);
      if (abort) begin
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        model_reset();
        check_idle_outputs("abort");
        return;
      end
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        step();
        chk("wait_desch2", 32'(deschedule), 32'(1) << w);
      end
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      if (s) begin
        m_cwp[w] = (m_cwp[w] + 1) % 4;
        m_spl[w]++;
      end else begin
        m_cwp[w] = (m_cwp[w] + 3) % 4;
        m_spl[w]--;
      end
      check_idle_outputs("done");
    end else begin
      chk("err_ovf", 32'(err_overflow), 32'(s));
      chk("err_unf", 32'(err_underflow), 32'(!s));
      chk("err_ready", 32'(op_ready), 1);
      step();
      chk("err_ovf_clr", 32'(err_overflow), 0);
      chk("err_unf_clr", 32'(err_underflow), 0);
    end
    check_decode("post", w);
  endtask

  initial begin
    nRST = 1'b0; op_valid = 1'b0; op_save = 1'b0; op_warp = '0;
    mem_ready = 1'b0; mem_done = 1'b0;
    dec_warp = 2'd2; rd = 5'd3; rs1 = 5'd10; rs2 = 5'd26;
    model_reset();
    step();
    step();
    chk("rst_rd",   32'(rd_o), 147);
    chk("rst_rs1",  32'(rs1_o), 154);
    chk("rst_rs2",  32'(rs2_o), 170);
    chk("rst_ovf",  32'(err_overflow), 0);
    chk("rst_unf",  32'(err_underflow), 0);
    chk("rst_warp", 32'(mem_warp), 0);
    chk("rst_cnt",  32'(mem_count), 0);
    check_idle_outputs("rst");
    nRST = 1'b1;

    // Window aliasing: caller r26 becomes callee r10.
    do_op(2, 1'b1, 1'b0);
    dec_warp = 2'd2; rs1 = 5'd10;
    #1;
    chk("alias_rs1", 32'(rs1_o), 170);

    // Third save on warp 0 spills window 0 (base 8); restores then fill it back.
    for (int i = 0; i < 3; i++) do_op(0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_op(0, 1'b0, 1'b0);

    // Underflow from reset state, then saturate the spill depth to overflow.
    do_op(1, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) do_op(3, 1'b1, 1'b0);

    for (int i = 0; i < 250; i++)
      do_op($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);

    // Reset while a spill waits for mem_done.
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) do_op(1, 1'b1, 1'b0);
    do_op(1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) check_decode("after_abort", i);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vx_reg_window_mgr.md
Name: vx_reg_window_mgr

Overview:
Per-warp register-window manager for the Vortex issue stage. It tracks a current window pointer (CWP) for each warp and remaps architectural register indices to physical register-file indices. Save and restore operations move the window. It raises spill/fill requests to an external memory engine on window overflow or underflow, and deschedules the affected warp until the transfer completes.

Parameters:
NUM_WARPS, 4, warp count; WB = clog2(NUM_WARPS)
R, 5, architectural register index width (2^R arch regs)
NUM_GLOBALS, 8, arch regs 0..NUM_GLOBALS-1 are per-warp globals, never windowed
NUM_WINDOWS, 4, physical windows per warp; power of two
STRIDE, 16, registers between consecutive windows (ins+locals); window size WSZ = 2^R-NUM_GLOBALS = 24
DEPTH_BITS, 4, width of per-warp spilled-window counter
Derived: PER_WARP = NUM_GLOBALS+NUM_WINDOWS*STRIDE (72); P = clog2(NUM_WARPS*PER_WARP) (9)

Ports:
clk  in  1  clock
nRST  in  1  reset
op_valid  in  1  save/restore request
op_save  in  1  1=save, 0=restore
op_warp  in  WB  warp issuing op
op_ready  out  1  op accepted when op_valid&op_ready
dec_warp  in  WB  warp for register decode
rs1, rs2, rd  in  R  architectural indices
rs1_o, rs2_o, rd_o  out  P  physical indices
deschedule  out  NUM_WARPS  per-warp stall to warp scheduler
spill_valid  out  1  spill request
fill_valid  out  1  fill request
mem_ready  in  1  engine accepts spill/fill request
mem_warp  out  WB  warp of transfer
mem_base  out  P  first physical reg of transfer
mem_count  out  clog2(STRIDE)+1  registers to transfer (always STRIDE)
mem_done  in  1  transfer finished
err_overflow  out  1  one-cycle pulse
err_underflow  out  1  one-cycle pulse

Behaviour:
- Reset: synchronous, active-low nRST. Applies to every state and output.
  - Per warp: cwp=0, resident=1, spilled=0. FSM=IDLE.
  - Outputs: spill_valid=fill_valid=0, deschedule=0, err_*=0, mem_*=0.
  - A reset mid-transfer aborts the transfer. No CWP commit occurs.
- Decode (combinational, uses registered cwp[dec_warp]):
  - Arch r < NUM_GLOBALS: phys = dec_warp*PER_WARP + r.
  - Otherwise: off = r-NUM_GLOBALS; phys = dec_warp*PER_WARP + NUM_GLOBALS + ((cwp*STRIDE + off) mod (NUM_WINDOWS*STRIDE)).
  - The caller's outs alias the callee's ins.
- op_ready = (FSM==IDLE). Ops are ignored while not ready.
- FSM states: IDLE, SPILL_REQ, FILL_REQ, WAIT_DONE.
- Accepted save, resident < NUM_WINDOWS-1:
  - Next cycle: cwp+1 (mod NUM_WINDOWS), resident+1.
  - No stall.
- Accepted save, resident == NUM_WINDOWS-1, spilled < 2^DEPTH_BITS-1:
  - FSM goes to SPILL_REQ. deschedule[op_warp] is set next cycle.
  - spill_valid=1 with mem_warp=op_warp, mem_base = warp base + NUM_GLOBALS + o*STRIDE, mem_count=STRIDE.
  - o = (cwp - resident + 1) mod NUM_WINDOWS (the oldest resident window).
  - spill_valid holds, with outputs stable, until mem_ready. Then FSM goes to WAIT_DONE.
  - On mem_done: cwp+1, spilled+1, resident unchanged, FSM goes to IDLE. deschedule bit clears the following cycle.
- Accepted save, spilled saturated: err_overflow pulses. No state change.
- Accepted restore, resident > 1: next cycle cwp-1, resident-1.
- Accepted restore, resident == 1, spilled > 0:
  - FSM goes to FILL_REQ. fill_valid=1, with mem_base for window (cwp-1) mod NUM_WINDOWS.
  - Then WAIT_DONE. On mem_done: cwp-1, spilled-1, resident stays 1.
- Accepted restore, resident == 1, spilled == 0: err_underflow pulses. No state change.
- mem_done outside WAIT_DONE is ignored. mem_done in the same cycle as mem_ready is not accepted; WAIT_DONE is always at least one cycle.
- Op accepted and decode of the same warp in the same cycle: decode reflects the pre-op cwp.
- Other warps' decode and state are unaffected during a transfer. Their ops stall via op_ready=0.

Test Plan:
- Reset, dec_warp=2, rd=3, rs1=10, rs2=26 (cwp=0) -> rd_o=147, rs1_o=154, rs2_o=170. All outputs 0 except decode.
- Warp 2 save (no trap), then rs1=10 -> rs1_o=170 (caller out r26 aliases callee in r10). op_ready stays 1.
- Warp 0: three saves -> third save (resident=3) gives spill_valid, mem_base=8, mem_count=16, deschedule=4'b0001.
  - Hold mem_ready=0 for 5 cycles: outputs stable.
  - Then mem_ready, then mem_done -> cwp=3, spilled=1, deschedule clears, op_ready=1.
- From the previous state, restores until resident=1, then one more restore -> fill_valid with mem_base=8+((cwp-1) mod 4)*16. After mem_done: spilled=0.
- Warp 1 restore from reset -> err_underflow single pulse; cwp stays 0. Saturate spilled to 15, then save at resident=3 -> err_overflow.
- nRST low during WAIT_DONE -> next cycle FSM=IDLE, deschedule=0, spill_valid=0, cwp of all warps=0.
